// File: rtl/steer_en_sm_if.sv
// Load-cell sample bus into the steering enable controller and its status outputs back.
interface steer_en_sm_if;
    logic        vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    // Sensor / testbench side: drives samples, observes status
    modport master (
        output vld,
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off
    );

    // Controller side
    modport slave (
        input  vld,
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off
    );
endinterface

// File: rtl/steer_en_sm.sv
// Steering enable state machine: decides rider presence and balance from the
// captured left/right load-cell readings and enables steering after a settle time.
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [11:0] WT_HYSTERESIS = 12'h040,
    parameter bit          FAST_SIM      = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    steer_en_sm_if.slave  bus
);

    localparam int unsigned TMR_W  = FAST_SIM ? 15 : 26;
    localparam int unsigned SUM_W  = 13;
    localparam logic [SUM_W-1:0] ON_THR  = SUM_W'(MIN_RIDER_WT);
    localparam logic [SUM_W-1:0] OFF_THR = SUM_W'(MIN_RIDER_WT) - SUM_W'(WT_HYSTERESIS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [11:0]        lft_q;
    logic [11:0]        rght_q;
    logic [TMR_W-1:0]   tmr;
    logic               tmr_clr;
    logic               tmr_inc;

    logic [SUM_W-1:0]   sum;
    logic [11:0]        diff;
    logic               sum_gt_min;
    logic               sum_lt_min;
    logic               diff_gt_1_4;
    logic               diff_gt_15_16;
    logic               tmr_full;

    // Capture new conversion results on the vld strobe, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= 12'd0;
            rght_q <= 12'd0;
        end else if (bus.vld) begin
            lft_q  <= bus.lft_ld;
            rght_q <= bus.rght_ld;
        end
    end

    // Weight and balance qualifiers from the captured readings (all 13-bit unsigned)
    always_comb begin
        sum           = SUM_W'(lft_q) + SUM_W'(rght_q);
        diff          = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        sum_gt_min    = (sum > ON_THR);
        sum_lt_min    = (sum < OFF_THR);
        diff_gt_1_4   = (SUM_W'(diff) > (sum >> 2));
        diff_gt_15_16 = (SUM_W'(diff) > (sum - (sum >> 4)));
        tmr_full      = &tmr;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state and timer control; tmr_full always leaves WAIT so the timer never wraps
    always_comb begin
        nxt_state = state;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt_state = WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_1_4) begin
                    tmr_clr   = 1'b1;
                end else if (tmr_full) begin
                    nxt_state = STEER;
                end else begin
                    tmr_inc   = 1'b1;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt_state = WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Settle timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (tmr_clr) begin
            tmr <= '0;
        end else if (tmr_inc) begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // Registered status outputs, updated in lockstep with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.en_steer  <= 1'b0;
            bus.rider_off <= 1'b1;
        end else begin
            bus.en_steer  <= (nxt_state == STEER);
            bus.rider_off <= (nxt_state == IDLE);
        end
    end

endmodule

// File: tb/tb_steer_en_sm.sv
// Testbench for steer_en_sm (FAST_SIM=1): directed scenarios plus random samples,
// every cycle compared against a cycle-counting reference model.
module tb_steer_en_sm;

    localparam int MIN_WT   = 512;
    localparam int HYST     = 64;
    localparam int SETTLE   = 32768;          // 2^15 cycles in WAIT
    localparam int LAST_CNT = SETTLE - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference model: captured readings, mode (0 none, 1 settling, 2 steering),
    // and number of balanced cycles seen since settling began
    int m_l, m_r, m_mode, m_cnt;

    always #5 clk = ~clk;

    steer_en_sm_if bus ();

    steer_en_sm #(
        .MIN_RIDER_WT (12'h200),
        .WT_HYSTERESIS(12'h040),
        .FAST_SIM     (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_l = 0; m_r = 0; m_mode = 0; m_cnt = 0;
    endtask

    // One clock edge of the rider rules, using readings captured before the edge
    task automatic model_edge();
        int s, d;
        s = m_l + m_r;
        d = (m_l > m_r) ? m_l - m_r : m_r - m_l;
        case (m_mode)
            0: if (s > MIN_WT) begin m_mode = 1; m_cnt = 0; end
            1: begin
                if (s < MIN_WT - HYST)   m_mode = 0;
                else if (d > s / 4)      m_cnt = 0;
                else if (m_cnt == LAST_CNT) m_mode = 2;
                else                     m_cnt++;
            end
            default: begin
                if (s < MIN_WT - HYST)       m_mode = 0;
                else if (d > s - s / 16) begin m_mode = 1; m_cnt = 0; end
            end
        endcase
        if (bus.vld) begin
            m_l = int'(bus.lft_ld);
            m_r = int'(bus.rght_ld);
        end
    endtask

    // Advance one clock, update model, compare outputs just after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk_bit("en_steer_model",  bus.en_steer,  m_mode == 2);
        chk_bit("rider_off_model", bus.rider_off, m_mode == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present one sample with vld for a single cycle
    task automatic drive(input int l, input int r);
        bus.vld     = 1'b1;
        bus.lft_ld  = 12'(l);
        bus.rght_ld = 12'(r);
        tick();
        bus.vld     = 1'b0;
    endtask

    // Count cycles until en_steer rises, bounded
    task automatic cycles_to_steer(input string tag, input int exp);
        int n = 0;
        while (bus.en_steer !== 1'b1 && n < SETTLE + 2000) begin
            tick();
            n++;
        end
        chk_int(tag, n, exp);
    endtask

    // Async reset pulse in the middle of a clock low/high phase, no edge involved
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_bit({tag, "_en"},  bus.en_steer,  1'b0);
        chk_bit({tag, "_off"}, bus.rider_off, 1'b1);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.vld     = 1'b0;
        bus.lft_ld  = 12'd0;
        bus.rght_ld = 12'd0;
        model_reset();

        // Power-on reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk_bit("por_en",  bus.en_steer,  1'b0);
        chk_bit("por_off", bus.rider_off, 1'b1);
        #5;
        rst = 1'b0;

        // Threshold boundaries from IDLE: 512 stays, 513 mounts
        drive(12'h100, 12'h100);
        ticks(3);
        chk_bit("sum512_idle", bus.rider_off, 1'b1);
        drive(12'h101, 12'h100);
        tick();
        chk_bit("sum513_mount", bus.rider_off, 1'b0);

        // Random samples: full range, then clustered around the thresholds
        for (int i = 0; i < 400; i++) begin
            bus.vld     = 1'($urandom_range(0, 1));
            if (i < 200) begin
                bus.lft_ld  = 12'($urandom);
                bus.rght_ld = 12'($urandom);
            end else begin
                bus.lft_ld  = 12'($urandom_range(180, 300));
                bus.rght_ld = 12'($urandom_range(180, 300));
            end
            tick();
        end
        bus.vld = 1'b0;

        // Step off completely
        drive(0, 0);
        ticks(2);
        chk_bit("empty_idle", bus.rider_off, 1'b1);

        // Mount balanced: rider_off falls after two edges
        drive(12'h180, 12'h180);
        chk_bit("mount_edge1", bus.rider_off, 1'b1);
        tick();
        chk_bit("mount_edge2", bus.rider_off, 1'b0);

        // Imbalance partway through settling restarts the settle time
        ticks(1000);
        drive(12'h200, 12'h080);
        ticks(49);
        chk_bit("imbal_no_steer", bus.en_steer, 1'b0);
        drive(12'h180, 12'h180);
        cycles_to_steer("rebalance_settle", SETTLE);

        // In STEER: sum 480 within hysteresis, moderate imbalance tolerated
        drive(12'h0F0, 12'h0F0);
        ticks(3);
        chk_bit("steer_sum480", bus.en_steer, 1'b1);
        drive(12'h300, 12'h040);
        ticks(3);
        chk_bit("steer_diff704", bus.en_steer, 1'b1);
        drive(12'h3C0, 12'h000);
        tick();
        chk_bit("stepoff_en", bus.en_steer, 1'b0);
        chk_bit("stepoff_wait", bus.rider_off, 1'b0);

        // In WAIT: 480 holds, 440 drops to IDLE, 500 does not remount
        drive(12'h0F0, 12'h0F0);
        ticks(3);
        chk_bit("wait_sum480", bus.rider_off, 1'b0);
        drive(12'h0DC, 12'h0DC);
        tick();
        chk_bit("wait_sum440", bus.rider_off, 1'b1);
        drive(12'h0FA, 12'h0FA);
        ticks(5);
        chk_bit("idle_sum500", bus.rider_off, 1'b1);

        // Remount, reset deep into WAIT, then a fresh mount needs the full settle
        drive(12'h180, 12'h180);
        tick();
        ticks(12000);
        chk_bit("wait_12000", bus.en_steer, 1'b0);
        mid_cycle_reset("rst_mid_wait");
        drive(12'h180, 12'h180);
        tick();
        chk_bit("remount", bus.rider_off, 1'b0);
        cycles_to_steer("remount_settle", SETTLE);

        // From STEER, sum 440 goes straight to IDLE
        drive(12'h0DC, 12'h0DC);
        tick();
        chk_bit("steer_sum440_en",  bus.en_steer,  1'b0);
        chk_bit("steer_sum440_off", bus.rider_off, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
